// File: rtl/cordic_pkg.sv
// Shared CORDIC datapath definitions: default datapath width, counter width and the
// carry-save source FSM state encoding.
package cordic_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned CNT_W     = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        StAccum,
        StIssue,
        StWait,
        StDone
    } state_e;

    // Saturating-free increment kept in the counter width so comparisons stay width-matched.
    function automatic cnt_t cnt_inc(input cnt_t c);
        return c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational WIDTH-bit 3:2 compressor: bitwise sum plus majority carry shifted up one
// place, top carry bit discarded.
module csa_row #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] carry_o
);

    logic [WIDTH-1:0] maj;

    assign sum_o   = a_i ^ b_i ^ c_i;
    assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    assign carry_o = maj << 1;

endmodule

// File: rtl/csa_vec_source.sv
// Carry-save sample accumulator feeding sgn_detect: accumulates N_SAMPLES samples into
// (VS, VC), strobes the detector, then reports its sign or a timeout.
// Optional build macro CPA_CHECK_EN adds a carry-propagate cross-check (res_sum, res_mismatch).
module csa_vec_source
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH     = cordic_pkg::WIDTH_DEF,
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] VS,
    output logic [WIDTH-1:0] VC,
    output logic             data_out,
    input  logic             sgn_valid,
    input  logic             sgn_in,
    output logic             res_valid,
    output logic             res_sgn,
    output logic             res_timeout,
`ifdef CPA_CHECK_EN
    output logic [WIDTH-1:0] res_sum,
    output logic             res_mismatch,
`endif
    output logic             busy
);

    localparam cnt_t SampleLim  = cnt_t'(N_SAMPLES);
    localparam cnt_t TimeoutLim = cnt_t'(TIMEOUT);

    state_e           state_q;
    logic [WIDTH-1:0] vs_q, vc_q;
    cnt_t             cnt_q, tmo_q;
    logic             res_sgn_q, res_tmo_q;
    logic [WIDTH-1:0] csa_sum, csa_carry;
    logic             accept;
    cnt_t             cnt_nxt, tmo_nxt;

`ifdef CPA_CHECK_EN
    logic [WIDTH-1:0] res_sum_q;
    logic             res_mis_q;
`endif

    csa_row #(
        .WIDTH (WIDTH)
    ) u_csa_row (
        .a_i     (vs_q),
        .b_i     (vc_q),
        .c_i     (in_data),
        .sum_o   (csa_sum),
        .carry_o (csa_carry)
    );

    assign in_ready = (state_q == StAccum);
    assign data_out = (state_q == StIssue);
    assign busy     = (state_q == StIssue) || (state_q == StWait);
    assign res_valid = (state_q == StDone);
    assign accept   = in_valid && in_ready;
    assign cnt_nxt  = cnt_inc(cnt_q);
    assign tmo_nxt  = cnt_inc(tmo_q);

    assign VS          = vs_q;
    assign VC          = vc_q;
    assign res_sgn     = res_sgn_q;
    assign res_timeout = res_tmo_q;

`ifdef CPA_CHECK_EN
    assign res_sum      = res_sum_q;
    assign res_mismatch = res_mis_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StAccum;
            vs_q      <= '0;
            vc_q      <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            res_sgn_q <= 1'b0;
            res_tmo_q <= 1'b0;
`ifdef CPA_CHECK_EN
            res_sum_q <= '0;
            res_mis_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (accept) begin
                        vs_q  <= csa_sum;
                        vc_q  <= csa_carry;
                        cnt_q <= cnt_nxt;
                        if (cnt_nxt == SampleLim) begin
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    tmo_q   <= '0;
                    state_q <= StWait;
`ifdef CPA_CHECK_EN
                    res_sum_q <= vs_q + vc_q;
`endif
                end
                StWait: begin
                    tmo_q <= tmo_nxt;
                    // A sign arriving on the limit cycle still takes priority over the abort.
                    if (sgn_valid) begin
                        res_sgn_q <= sgn_in;
                        res_tmo_q <= 1'b0;
                        state_q   <= StDone;
`ifdef CPA_CHECK_EN
                        res_mis_q <= res_sum_q[WIDTH-1] ^ sgn_in;
`endif
                    end else if (tmo_nxt >= TimeoutLim) begin
                        res_sgn_q <= 1'b0;
                        res_tmo_q <= 1'b1;
                        state_q   <= StDone;
`ifdef CPA_CHECK_EN
                        res_mis_q <= 1'b0;
`endif
                    end
                end
                StDone: begin
                    vs_q    <= '0;
                    vc_q    <= '0;
                    cnt_q   <= '0;
                    tmo_q   <= '0;
                    state_q <= StAccum;
                end
                default: begin
                    state_q <= StAccum;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_vec_source.sv
// Scoreboard bench for csa_vec_source with a behavioural sign-detector model.
module tb_csa_vec_source;

    localparam int W  = 16;
    localparam int NS = 8;
    localparam int TO = 15;

    typedef struct packed {
        logic          sgn;
        logic          tmo;
        logic [W-1:0]  sum;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] VS, VC;
    logic         data_out;
    logic         sgn_valid;
    logic         sgn_in;
    logic         res_valid;
    logic         res_sgn;
    logic         res_timeout;
    logic         busy;
`ifdef CPA_CHECK_EN
    logic [W-1:0] res_sum;
    logic         res_mismatch;
`endif

    int n_vec = 0;
    int n_bad = 0;

    exp_t         exp_q[$];
    logic [W-1:0] sum_q[$];
    logic [W-1:0] smp[NS];

    bit   det_en  = 1'b0;
    logic det_sgn = 1'b0;
    bit   spur_en = 1'b0;
    bit   pend    = 1'b0;

    csa_vec_source #(
        .WIDTH     (W),
        .N_SAMPLES (NS),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .VS          (VS),
        .VC          (VC),
        .data_out    (data_out),
        .sgn_valid   (sgn_valid),
        .sgn_in      (sgn_in),
        .res_valid   (res_valid),
        .res_sgn     (res_sgn),
        .res_timeout (res_timeout),
`ifdef CPA_CHECK_EN
        .res_sum     (res_sum),
        .res_mismatch(res_mismatch),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] add_w(input logic [W-1:0] a, input logic [W-1:0] b);
        return a + b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_VS", 32'(VS), 32'd0);
        chk("rst_VC", 32'(VC), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_sgn", 32'(res_sgn), 32'd0);
        chk("rst_res_timeout", 32'(res_timeout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    // Detector model: answers one cycle after the issue strobe with the sign of the true sum.
    initial begin
        sgn_valid = 1'b0;
        sgn_in    = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                sgn_valid = 1'b1;
                sgn_in    = det_sgn;
            end else if (spur_en && in_ready && $urandom_range(0, 2) == 0) begin
                sgn_valid = 1'b1;
                sgn_in    = 1'($urandom_range(0, 1));
            end else begin
                sgn_valid = 1'b0;
                sgn_in    = 1'($urandom_range(0, 1));
            end
            pend = data_out && det_en && !reset;
        end
    end

    // Monitors: compare against scoreboard queues whenever the DUT presents an output.
    initial begin
        exp_t         e;
        logic [W-1:0] s;
        forever begin
            @(negedge clk);
            if (data_out) begin
                if (sum_q.size() == 0) begin
                    chk("issue_unexpected", 32'd1, 32'd0);
                end else begin
                    s = sum_q.pop_front();
                    chk("issue_sum", 32'(add_w(VS, VC)), 32'(s));
                end
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("result_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_sgn", 32'(res_sgn), 32'(e.sgn));
                    chk("res_timeout", 32'(res_timeout), 32'(e.tmo));
`ifdef CPA_CHECK_EN
                    chk("res_sum", 32'(res_sum), 32'(e.sum));
                    chk("res_mismatch", 32'(res_mismatch), 32'd0);
`endif
                end
            end
        end
    end

    task automatic run_batch(input bit toggle, input bit respond, input bit spur,
                             input bit rst_in_wait);
        int           n = 0;
        int           k;
        int           guard = 0;
        bit           acc = 1'b0;
        bit           seen = 1'b0;
        logic [W-1:0] ref_sum = '0;
        logic [W-1:0] total = '0;
        exp_t         e;

        for (int i = 0; i < NS; i++) total = total + smp[i];
        det_en  = respond;
        det_sgn = total[W-1];
        spur_en = spur;

        while (n < NS) begin
            @(negedge clk);
            if (acc) chk("invariant", 32'(add_w(VS, VC)), 32'(ref_sum));
            in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = smp[n];
            acc      = in_valid && in_ready;
            if (acc) begin
                ref_sum = ref_sum + smp[n];
                n++;
            end
            guard++;
            if (guard > 300) begin
                chk("accept_timeout", 32'(n), 32'(NS));
                in_valid = 1'b0;
                return;
            end
        end

        sum_q.push_back(ref_sum);
        if (!rst_in_wait) begin
            e.sgn = respond ? total[W-1] : 1'b0;
            e.tmo = !respond;
            e.sum = total;
            exp_q.push_back(e);
        end

        @(negedge clk);
        spur_en  = 1'b0;
        in_valid = 1'($urandom_range(0, 1));
        in_data  = W'($urandom_range(0, 65535));
        chk("invariant_last", 32'(add_w(VS, VC)), 32'(ref_sum));
        chk("issue_strobe", 32'(data_out), 32'd1);
        chk("issue_ready", 32'(in_ready), 32'd0);
        chk("issue_busy", 32'(busy), 32'd1);

        if (rst_in_wait) begin
            @(negedge clk);
            @(negedge clk);
            chk("wait_busy", 32'(busy), 32'd1);
            reset = 1'b1;
            @(negedge clk);
            chk_reset_vals();
            reset    = 1'b0;
            in_valid = 1'b0;
            return;
        end

        k = 1;
        while (!seen && k < 60) begin
            @(negedge clk);
            k++;
            in_valid = 1'($urandom_range(0, 1));
            chk("ready_low", 32'(in_ready), 32'd0);
            chk("no_restrobe", 32'(data_out), 32'd0);
            if (res_valid) begin
                seen = 1'b1;
                chk("done_busy", 32'(busy), 32'd0);
            end else begin
                chk("wait_busy", 32'(busy), 32'd1);
            end
        end
        chk("latency", 32'(k), respond ? 32'd3 : 32'(TO + 2));
        in_valid = 1'b0;

        @(negedge clk);
        chk("restart_VS", 32'(VS), 32'd0);
        chk("restart_VC", 32'(VC), 32'd0);
        chk("restart_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;
        @(negedge clk);

        // 1..8 -> 36, positive
        for (int i = 0; i < NS; i++) smp[i] = W'(i + 1);
        run_batch(1'b0, 1'b1, 1'b0, 1'b0);

        // eight -5 -> 0xFFD8, negative
        for (int i = 0; i < NS; i++) smp[i] = 16'hFFFB;
        run_batch(1'b0, 1'b1, 1'b0, 1'b0);

        // eight 0x7000 -> wraps to 0x8000
        for (int i = 0; i < NS; i++) smp[i] = 16'h7000;
        run_batch(1'b0, 1'b1, 1'b0, 1'b0);

        // detector silent -> timeout
        for (int i = 0; i < NS; i++) smp[i] = W'(i + 1);
        run_batch(1'b0, 1'b0, 1'b0, 1'b0);

        // random samples, handshake toggling, spurious signs during accumulation
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < NS; i++) smp[i] = W'($urandom_range(0, 65535));
            run_batch(1'b1, (b % 3) != 2, 1'b1, 1'b0);
        end

        // timeout result so res_timeout is set, then reset in the middle of WAIT
        for (int i = 0; i < NS; i++) smp[i] = 16'hFFFF;
        run_batch(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NS; i++) smp[i] = W'($urandom_range(0, 65535));
        run_batch(1'b1, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < NS; i++) smp[i] = W'(i + 1);
        run_batch(1'b0, 1'b1, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("sum_q_drained", 32'(sum_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/csa_vec_source.md
# csa_vec_source

Producer side of the redundant-vector sign interface. It accumulates a stream of signed 16-bit samples into carry-save form (VS, VC). After a fixed number of samples it presents the pair to `sgn_detect` with a one-cycle issue strobe, then waits for the detector's sign and reports it as a result. It sits upstream of `sgn_detect` in the CORDIC datapath and drives that block's VS, VC and data_in. It consumes the detector's data_out and sgn.

## Interface
Parameters:
- WIDTH, 16, datapath width of samples, VS and VC.
- N_SAMPLES, 8, samples accumulated per issue (range 1–255).
- TIMEOUT, 15, maximum cycles spent in WAIT before abort (range 1–255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  WIDTH  two's-complement sample.
- VS  out  WIDTH  carry-save sum vector, to detector.
- VC  out  WIDTH  carry-save carry vector, to detector.
- data_out  out  1  issue strobe, to detector data_in.
- sgn_valid  in  1  detector data_out; sgn_in is valid while high.
- sgn_in  in  1  detector sign (1 = negative).
- res_valid  out  1  one-cycle result strobe.
- res_sgn  out  1  captured sign.
- res_timeout  out  1  result aborted by timeout; qualified by res_valid.
- busy  out  1  high in ISSUE and WAIT.

## Operation
- State machine: ACCUM, ISSUE, WAIT, DONE. Reset enters ACCUM.
- ACCUM:
  - in_ready=1; a sample is accepted when in_valid & in_ready.
  - Each accepted sample x updates the vectors as a 3:2 compression:
    - VS' = VS ^ VC ^ x
    - VC' = ((VS&VC)|(VS&x)|(VC&x)) << 1, with the bit shifted out of the top discarded.
  - Invariant: (VS+VC) mod 2^WIDTH equals the running sum of accepted samples mod 2^WIDTH. Wrap-around is silent.
  - When the sample count reaches N_SAMPLES, go to ISSUE.
- ISSUE: data_out=1 for exactly one cycle; go to WAIT.
- WAIT:
  - The timeout counter increments each cycle.
  - If sgn_valid=1: capture sgn_in into res_sgn, clear res_timeout, go to DONE.
  - Otherwise, if the counter has reached TIMEOUT: set res_sgn=0 and res_timeout=1, go to DONE.
  - If sgn_valid=1 arrives on the same cycle the limit is reached, the sign wins.
- DONE:
  - res_valid=1 for one cycle.
  - Clear VS, VC, the sample count and the timeout counter; return to ACCUM.
- VS and VC hold their values through ISSUE and WAIT; they change only in ACCUM and DONE.
- in_ready=0 in ISSUE, WAIT and DONE; input is back-pressured.
- sgn_valid outside WAIT is ignored.

## Timing
- Reset values: in_ready=1 (combinational from state), VS=0, VC=0, data_out=0, res_valid=0, res_sgn=0, res_timeout=0, busy=0. All counters are 0.
- in_ready, busy and data_out are decoded from the state register.
- VS, VC, res_sgn and res_timeout are registered.
- Sample acceptance: VS and VC update on the same edge the sample is accepted.
- The edge accepting the Nth sample moves the FSM to ISSUE.
- With the codebase detector (response one cycle after data_in), a result costs 4 cycles after the last sample: ISSUE, WAIT (1 cycle), DONE, then back in ACCUM. Throughput is N_SAMPLES+3 cycles per result.
- Reset asserted mid-operation (any state) returns the block to ACCUM with all reset values immediately. No partial result is issued.

## Configuration
- CPA_CHECK_EN defined:
  - Adds outputs res_sum (WIDTH) and res_mismatch (1).
  - In ISSUE, register res_sum = (VS+VC) mod 2^WIDTH.
  - In DONE, res_mismatch = res_sum[WIDTH-1] != res_sgn. It is forced to 0 on timeout.
- CPA_CHECK_EN undefined: neither port exists and no adder is built.

## Structure
- Shared package `cordic_pkg`:
  - WIDTH default.
  - State enum (ACCUM, ISSUE, WAIT, DONE).
  - Counter width constant (8 bits).
- Sub-module `csa_row`: combinational WIDTH-bit 3:2 compressor producing sum and shifted carry. It is instantiated once.

## Test plan
- Samples 1..8 with in_valid held high -> one data_out pulse; at issue (VS+VC) mod 2^16 = 36; bench detector model returns sgn=0; res_valid with res_sgn=0, res_timeout=0.
- Eight samples of -5 (0xFFFB) -> (VS+VC) = 0xFFD8; model returns 1; res_sgn=1. With CPA_CHECK_EN: res_sum=0xFFD8, res_mismatch=0.
- Eight samples of 0x7000 -> sum wraps to 0x8000; model returns 1; no error flagged. Verify the invariant after every accepted sample.
- Detector model never responds -> res_valid after TIMEOUT WAIT cycles with res_timeout=1, res_sgn=0; accumulation restarts from VS=VC=0.
- in_valid toggling at random -> only handshaken samples counted. Spurious sgn_valid during ACCUM is ignored. in_ready=0 throughout ISSUE/WAIT/DONE.
- Reset asserted during WAIT -> all outputs at reset values on the next observation. A following run of samples 1..8 yields the 36 case.
